// File: rtl/simon_pkg.sv
// Shared state encoding, colour type and LFSR step function
// for the Simon round controller.
package simon_pkg;

   typedef enum logic [3:0] {
      IDLE         = 4'd0,
      GEN          = 4'd1,
      PLAY_ON      = 4'd2,
      PLAY_OFF     = 4'd3,
      WAIT_PRESS   = 4'd4,
      WAIT_RELEASE = 4'd5,
      CHECK        = 4'd6,
      OVER         = 4'd7,
      WIN          = 4'd8
   } state_t;

   typedef logic [1:0] colour_t;

   // Fibonacci step: taps 7,5,4,3, shifting toward the MSB.
   function automatic logic [7:0] lfsr_step(input logic [7:0] q);
      logic fb;
      fb = q[7] ^ q[5] ^ q[4] ^ q[3];
      return {q[6:0], fb};
   endfunction

endpackage

// File: rtl/simon_lfsr8.sv
// 8-bit colour source for the Simon game. Only advances when
// asked to, so the stream carries on across games.
module simon_lfsr8 #(
   parameter logic [7:0] SEED = 8'hA5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_step,
   output logic [7:0] o_state
);
   import simon_pkg::*;

   logic [7:0] r_q;

   // Reload the seed on reset, otherwise step when enabled.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_q <= SEED;
      end else if (i_step) begin
         r_q <= lfsr_step(r_q);
      end
   end

   assign o_state = r_q;

endmodule

// File: rtl/simon_round_ctrl.sv
// Simon round controller: grows the colour sequence, plays it
// back with timed pulses and checks the player's answers.
module simon_round_ctrl #(
   parameter int         MAX_LEN       = 16,
   parameter int         ON_TICKS      = 30,
   parameter int         OFF_TICKS     = 15,
   parameter int         TIMEOUT_TICKS = 300,
   parameter logic [7:0] SEED          = 8'hA5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [1:0] player_num,
   input  logic       player_pressed,
   output logic       simon_turn,
   output logic [1:0] simon_num,
   output logic       simon_pressed,
   output logic [4:0] round_len,
   output logic       game_over,
   output logic       win
);
   import simon_pkg::*;

   localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   localparam logic [15:0] L_ON_LAST  = 16'(ON_TICKS - 1);
   localparam logic [15:0] L_OFF_LAST = 16'(OFF_TICKS - 1);
   localparam logic [15:0] L_TO_LAST  = 16'(TIMEOUT_TICKS - 1);
   localparam logic [4:0]  L_MAX      = 5'(MAX_LEN);

   state_t      r_state;
   logic [4:0]  r_len;
   logic [4:0]  r_idx;
   logic [15:0] r_tick;
   colour_t     r_cap;
   colour_t     r_seq [MAX_LEN];
   logic        r_turn;
   logic        r_pressed;
   colour_t     r_num;
   logic        r_over;
   logic        r_win;

   logic [7:0]  w_lfsr_q;
   logic [7:0]  w_lfsr_nx;
   logic [5:0]  w_lfsr_unused;
   colour_t     w_new_col;
   logic [4:0]  w_idx_inc;
   logic        w_last;
   colour_t     w_seq_cur;
   colour_t     w_seq_nxt;
   logic        w_match;

   simon_lfsr8 #(
      .SEED (SEED)
   ) u_lfsr (
      .clk     (clk),
      .reset   (reset),
      .i_step  (r_state == GEN),
      .o_state (w_lfsr_q)
   );

   // New colour is the low pair of the value the LFSR steps to.
   assign w_lfsr_nx     = lfsr_step(w_lfsr_q);
   assign w_new_col     = w_lfsr_nx[1:0];
   assign w_lfsr_unused = w_lfsr_nx[7:2];

   assign w_idx_inc = r_idx + 5'd1;
   assign w_last    = (r_idx == r_len - 5'd1);
   assign w_seq_cur = r_seq[r_idx[IW-1:0]];
   assign w_seq_nxt = r_seq[w_idx_inc[IW-1:0]];
   assign w_match   = (r_cap == w_seq_cur);

   // Round FSM; outputs are loaded for the state being entered.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_len     <= 5'd0;
         r_idx     <= 5'd0;
         r_tick    <= 16'd0;
         r_cap     <= 2'd0;
         r_turn    <= 1'b0;
         r_pressed <= 1'b0;
         r_num     <= 2'd0;
         r_over    <= 1'b0;
         r_win     <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_state <= GEN;
                  r_turn  <= 1'b1;
               end
            end

            GEN: begin
               r_seq[r_len[IW-1:0]] <= w_new_col;
               r_len     <= r_len + 5'd1;
               r_idx     <= 5'd0;
               r_tick    <= 16'd0;
               r_state   <= PLAY_ON;
               r_pressed <= 1'b1;
               r_num     <= (r_len == 5'd0) ? w_new_col : r_seq[0];
            end

            PLAY_ON: begin
               if (r_tick == L_ON_LAST) begin
                  r_tick    <= 16'd0;
                  r_state   <= PLAY_OFF;
                  r_pressed <= 1'b0;
               end else begin
                  r_tick <= r_tick + 16'd1;
               end
            end

            PLAY_OFF: begin
               if (r_tick == L_OFF_LAST) begin
                  r_tick <= 16'd0;
                  if (w_last) begin
                     r_idx   <= 5'd0;
                     r_state <= WAIT_PRESS;
                     r_turn  <= 1'b0;
                  end else begin
                     r_idx     <= w_idx_inc;
                     r_state   <= PLAY_ON;
                     r_pressed <= 1'b1;
                     r_num     <= w_seq_nxt;
                  end
               end else begin
                  r_tick <= r_tick + 16'd1;
               end
            end

            WAIT_PRESS: begin
               if (player_pressed) begin
                  r_cap   <= player_num;
                  r_tick  <= 16'd0;
                  r_state <= WAIT_RELEASE;
               end else if (r_tick == L_TO_LAST) begin
                  r_state <= OVER;
                  r_over  <= 1'b1;
               end else begin
                  r_tick <= r_tick + 16'd1;
               end
            end

            WAIT_RELEASE: begin
               if (!player_pressed) begin
                  r_state <= CHECK;
               end
            end

            CHECK: begin
               if (!w_match) begin
                  r_state <= OVER;
                  r_over  <= 1'b1;
               end else if (!w_last) begin
                  r_idx   <= w_idx_inc;
                  r_tick  <= 16'd0;
                  r_state <= WAIT_PRESS;
               end else if (r_len == L_MAX) begin
                  r_state <= WIN;
                  r_win   <= 1'b1;
               end else begin
                  r_state <= GEN;
                  r_turn  <= 1'b1;
               end
            end

            OVER, WIN: begin
               if (start) begin
                  r_len   <= 5'd0;
                  r_state <= GEN;
                  r_turn  <= 1'b1;
                  r_over  <= 1'b0;
                  r_win   <= 1'b0;
               end
            end

            default: begin
               r_state   <= IDLE;
               r_len     <= 5'd0;
               r_idx     <= 5'd0;
               r_tick    <= 16'd0;
               r_turn    <= 1'b0;
               r_pressed <= 1'b0;
               r_over    <= 1'b0;
               r_win     <= 1'b0;
            end
         endcase
      end
   end

   assign simon_turn    = r_turn;
   assign simon_num     = r_num;
   assign simon_pressed = r_pressed;
   assign round_len     = r_len;
   assign game_over     = r_over;
   assign win           = r_win;

endmodule

// File: tb/tb_simon_round_ctrl.sv
// Directed bench for simon_round_ctrl with short timing
// parameters and a three-colour winning length.
module tb_simon_round_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [1:0] player_num;
   logic       player_pressed;
   logic       simon_turn;
   logic [1:0] simon_num;
   logic       simon_pressed;
   logic [4:0] round_len;
   logic       game_over;
   logic       win;

   int n_checks = 0;
   int n_fail   = 0;

   int         cap_n;
   int         cap_first;
   bit         cap_to;
   logic [1:0] cap_col [8];
   int         cap_w   [8];
   int         cap_gap [8];

   simon_round_ctrl #(
      .MAX_LEN       (3),
      .ON_TICKS      (2),
      .OFF_TICKS     (1),
      .TIMEOUT_TICKS (5),
      .SEED          (8'hA5)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .player_num     (player_num),
      .player_pressed (player_pressed),
      .simon_turn     (simon_turn),
      .simon_num      (simon_num),
      .simon_pressed  (simon_pressed),
      .round_len      (round_len),
      .game_over      (game_over),
      .win            (win)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Records the pulses of one playback (optionally pulsing start
   // first, optionally wiggling the player inputs meanwhile).
   task automatic capture(input bit with_start, input bit toggle);
      bit prev;
      prev      = 1'b0;
      cap_n     = 0;
      cap_first = 0;
      cap_to    = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cap_col[i] = 2'd0;
         cap_w[i]   = 0;
         cap_gap[i] = 0;
      end
      if (with_start) start = 1'b1;
      for (int k = 1; k <= 200; k++) begin
         if (toggle) begin
            player_pressed = ~player_pressed;
            player_num     = 2'(k);
         end
         tick();
         start = 1'b0;
         if (simon_pressed) begin
            if (!prev && cap_n < 8) begin
               if (cap_n == 0) cap_first = k;
               cap_col[cap_n] = simon_num;
            end
            if (cap_n < 8) cap_w[cap_n]++;
         end else if (prev) begin
            if (cap_n < 8) cap_gap[cap_n] = simon_turn ? 1 : 0;
            cap_n++;
         end else if (cap_n > 0 && cap_n <= 8 && simon_turn) begin
            cap_gap[cap_n-1]++;
         end
         prev = simon_pressed;
         if (!simon_turn && cap_n > 0) begin
            cap_to = 1'b0;
            break;
         end
      end
      if (toggle) begin
         player_pressed = 1'b0;
         player_num     = 2'd0;
      end
   endtask

   task automatic answer(input logic [1:0] c);
      player_num     = c;
      player_pressed = 1'b1;
      tick();
      tick();
      player_pressed = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      reset          = 1'b1;
      start          = 1'b0;
      player_num     = 2'd0;
      player_pressed = 1'b0;
      tick();
      tick();
      n_checks++;
      if ({simon_turn, simon_num, simon_pressed, round_len,
           game_over, win} !== 11'd0) begin
         n_fail++;
         $display("FAIL reset: outs turn=%b num=%0d pr=%b len=%0d ov=%b win=%b, required all 0",
                  simon_turn, simon_num, simon_pressed, round_len,
                  game_over, win);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_play();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      n_checks++;
      if (simon_pressed !== 1'b1 || simon_num !== 2'd2) begin
         n_fail++;
         $display("FAIL first_pulse: pressed=%b num=%0d, required pressed=1 num=2",
                  simon_pressed, simon_num);
      end
      reset = 1'b1;
      tick();
      n_checks++;
      if ({simon_turn, simon_num, simon_pressed, round_len,
           game_over, win} !== 11'd0) begin
         n_fail++;
         $display("FAIL mid_reset: turn=%b num=%0d pr=%b len=%0d ov=%b win=%b, required all 0",
                  simon_turn, simon_num, simon_pressed, round_len,
                  game_over, win);
      end
      reset = 1'b0;
      tick();
      tick();
      n_checks++;
      if (simon_turn !== 1'b0 || round_len !== 5'd0) begin
         n_fail++;
         $display("FAIL idle_hold: turn=%b len=%0d, required turn=0 len=0",
                  simon_turn, round_len);
      end
   endtask

   // Full winning game: LFSR steps 1..3 from A5 give 2,1,2.
   task automatic test_rounds();
      logic [1:0] exp [3];
      bit         seen;
      exp[0] = 2'd2;
      exp[1] = 2'd1;
      exp[2] = 2'd2;
      for (int r = 1; r <= 3; r++) begin
         capture(r == 1, 1'b0);
         n_checks++;
         if (cap_to || cap_n !== r || cap_first !== 2 ||
             round_len !== 5'(r)) begin
            n_fail++;
            $display("FAIL rounds_hdr r=%0d: to=%b n=%0d first=%0d len=%0d, required to=0 n=%0d first=2 len=%0d",
                     r, cap_to, cap_n, cap_first, round_len, r, r);
         end
         for (int i = 0; i < r; i++) begin
            n_checks++;
            if (cap_col[i] !== exp[i] || cap_w[i] !== 2 ||
                cap_gap[i] !== 1) begin
               n_fail++;
               $display("FAIL rounds_pulse r=%0d i=%0d: col=%0d w=%0d gap=%0d, required col=%0d w=2 gap=1",
                        r, i, cap_col[i], cap_w[i], cap_gap[i], exp[i]);
            end
         end
         for (int i = 0; i < r; i++) begin
            if (i > 0) tick();
            answer(exp[i]);
         end
      end
      tick();
      n_checks++;
      if (win !== 1'b1 || game_over !== 1'b0 || round_len !== 5'd3 ||
          simon_turn !== 1'b0 || simon_num !== 2'd2) begin
         n_fail++;
         $display("FAIL win: win=%b ov=%b len=%0d turn=%b num=%0d, required win=1 ov=0 len=3 turn=0 num=2",
                  win, game_over, round_len, simon_turn, simon_num);
      end
      seen = 1'b0;
      repeat (5) begin
         tick();
         if (simon_turn) seen = 1'b1;
      end
      n_checks++;
      if (seen || win !== 1'b1 || round_len !== 5'd3) begin
         n_fail++;
         $display("FAIL win_hold: turn_seen=%b win=%b len=%0d, required turn_seen=0 win=1 len=3",
                  seen, win, round_len);
      end
   endtask

   // New game continues the stream: steps 4,5 give 0,1.
   task automatic test_mismatch();
      capture(1'b1, 1'b0);
      n_checks++;
      if (cap_to || cap_n !== 1 || cap_col[0] !== 2'd0 ||
          cap_w[0] !== 2 || round_len !== 5'd1 || win !== 1'b0) begin
         n_fail++;
         $display("FAIL restart: to=%b n=%0d col=%0d w=%0d len=%0d win=%b, required to=0 n=1 col=0 w=2 len=1 win=0",
                  cap_to, cap_n, cap_col[0], cap_w[0], round_len, win);
      end
      answer(2'd0);
      capture(1'b0, 1'b0);
      n_checks++;
      if (cap_to || cap_n !== 2 || cap_col[0] !== 2'd0 ||
          cap_col[1] !== 2'd1 || round_len !== 5'd2) begin
         n_fail++;
         $display("FAIL mm_round2: to=%b n=%0d c0=%0d c1=%0d len=%0d, required to=0 n=2 c0=0 c1=1 len=2",
                  cap_to, cap_n, cap_col[0], cap_col[1], round_len);
      end
      answer(2'd0);
      tick();
      answer(2'd3);
      n_checks++;
      if (game_over !== 1'b0) begin
         n_fail++;
         $display("FAIL mm_check: game_over=%b, required 0", game_over);
      end
      tick();
      n_checks++;
      if (game_over !== 1'b1 || win !== 1'b0 || round_len !== 5'd2 ||
          simon_turn !== 1'b0) begin
         n_fail++;
         $display("FAIL mm_over: ov=%b win=%b len=%0d turn=%b, required ov=1 win=0 len=2 turn=0",
                  game_over, win, round_len, simon_turn);
      end
      repeat (3) tick();
      n_checks++;
      if (game_over !== 1'b1 || round_len !== 5'd2) begin
         n_fail++;
         $display("FAIL mm_hold: ov=%b len=%0d, required ov=1 len=2",
                  game_over, round_len);
      end
   endtask

   // Step 6 gives colour 3; nobody answers.
   task automatic test_timeout();
      capture(1'b1, 1'b0);
      n_checks++;
      if (cap_to || cap_n !== 1 || cap_col[0] !== 2'd3 ||
          round_len !== 5'd1 || game_over !== 1'b0) begin
         n_fail++;
         $display("FAIL to_play: to=%b n=%0d col=%0d len=%0d ov=%b, required to=0 n=1 col=3 len=1 ov=0",
                  cap_to, cap_n, cap_col[0], round_len, game_over);
      end
      repeat (4) tick();
      n_checks++;
      if (game_over !== 1'b0) begin
         n_fail++;
         $display("FAIL to_early: game_over=%b after 4 waits, required 0",
                  game_over);
      end
      tick();
      n_checks++;
      if (game_over !== 1'b1 || round_len !== 5'd1) begin
         n_fail++;
         $display("FAIL to_fire: ov=%b len=%0d after 5 waits, required ov=1 len=1",
                  game_over, round_len);
      end
   endtask

   // Step 7 gives 3, step 8 gives 2, step 9 gives 1.
   task automatic test_timeout_press();
      capture(1'b1, 1'b0);
      n_checks++;
      if (cap_to || cap_n !== 1 || cap_col[0] !== 2'd3) begin
         n_fail++;
         $display("FAIL tp_play: to=%b n=%0d col=%0d, required to=0 n=1 col=3",
                  cap_to, cap_n, cap_col[0]);
      end
      repeat (4) tick();
      player_num     = 2'd3;
      player_pressed = 1'b1;
      tick();
      n_checks++;
      if (game_over !== 1'b0) begin
         n_fail++;
         $display("FAIL tp_accept: game_over=%b, required 0", game_over);
      end
      tick();
      player_pressed = 1'b0;
      tick();
      capture(1'b0, 1'b0);
      n_checks++;
      if (cap_to || cap_n !== 2 || cap_col[0] !== 2'd3 ||
          cap_col[1] !== 2'd2 || round_len !== 5'd2) begin
         n_fail++;
         $display("FAIL tp_round2: to=%b n=%0d c0=%0d c1=%0d len=%0d, required to=0 n=2 c0=3 c1=2 len=2",
                  cap_to, cap_n, cap_col[0], cap_col[1], round_len);
      end
   endtask

   task automatic test_hold_latch();
      logic [1:0] exp [3];
      exp[0] = 2'd3;
      exp[1] = 2'd2;
      exp[2] = 2'd1;
      answer(2'd3);
      tick();
      answer(2'd2);
      capture(1'b0, 1'b1);
      n_checks++;
      if (cap_to || cap_n !== 3 || round_len !== 5'd3) begin
         n_fail++;
         $display("FAIL hl_hdr: to=%b n=%0d len=%0d, required to=0 n=3 len=3",
                  cap_to, cap_n, round_len);
      end
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (cap_col[i] !== exp[i] || cap_w[i] !== 2 ||
             cap_gap[i] !== 1) begin
            n_fail++;
            $display("FAIL hl_pulse i=%0d: col=%0d w=%0d gap=%0d, required col=%0d w=2 gap=1",
                     i, cap_col[i], cap_w[i], cap_gap[i], exp[i]);
         end
      end
      answer(2'd3);
      tick();
      answer(2'd2);
      tick();
      player_num     = 2'd1;
      player_pressed = 1'b1;
      tick();
      player_num     = 2'd0;
      tick();
      tick();
      player_pressed = 1'b0;
      tick();
      tick();
      n_checks++;
      if (win !== 1'b1 || game_over !== 1'b0 || round_len !== 5'd3) begin
         n_fail++;
         $display("FAIL hl_latch: win=%b ov=%b len=%0d, required win=1 ov=0 len=3",
                  win, game_over, round_len);
      end
   endtask

   initial begin
      test_reset();
      test_reset_mid_play();
      test_rounds();
      test_mismatch();
      test_timeout();
      test_timeout_press();
      test_hold_latch();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/simon_round_ctrl.md
Name: simon_round_ctrl

Overview:
Round controller for the Simon game. It generates and stores the colour sequence and plays it back with timed press/release pulses. It then collects and checks the player's presses one by one, and grows the sequence each round until a mismatch, a timeout or MAX_LEN is reached. It sits between the button/debounce logic and the LED/sound drivers, and runs on the 60 Hz game clock.

Parameters:
MAX_LEN, 16, maximum sequence length (winning length); 2..31
ON_TICKS, 30, cycles simon_pressed stays high per played colour
OFF_TICKS, 15, cycles of gap after each played colour
TIMEOUT_TICKS, 300, cycles allowed in WAIT_PRESS before game over
SEED, 8'hA5, LFSR reset value; must be nonzero

Ports:
clk  in  1  game clock (60 Hz)
reset  in  1  synchronous, active-high reset
start  in  1  level; sampled only in IDLE, OVER and WIN
player_num  in  2  colour currently held by player
player_pressed  in  1  player button held (debounced level)
simon_turn  out  1  high while the controller is generating or playing back
simon_num  out  2  colour being played; holds last played value otherwise
simon_pressed  out  1  high during each ON phase of playback
round_len  out  5  current sequence length (0 in IDLE)
game_over  out  1  high in OVER
win  out  1  high in WIN

Behaviour:
- Reset (synchronous, dominant, any state including mid-playback): state=IDLE, LFSR=SEED, len=0, idx=0, tick=0. All outputs are 0.
- LFSR: 8-bit Fibonacci register, shifting left. fb = q[7]^q[5]^q[4]^q[3], next = {q[6:0],fb}. It steps only in GEN and is never reseeded except by reset, so a later game continues the stream.
- IDLE: start=1 -> GEN.
- GEN (1 cycle): LFSR steps; seq[len] <= next[1:0]; len <= len+1; idx <= 0; tick <= 0 -> PLAY_ON. simon_turn=1.
- PLAY_ON: simon_num=seq[idx], simon_pressed=1, simon_turn=1. After exactly ON_TICKS cycles, tick clears -> PLAY_OFF.
- PLAY_OFF: simon_pressed=0, simon_turn=1. Lasts exactly OFF_TICKS cycles.
  - If idx==len-1: idx <= 0, tick <= 0 -> WAIT_PRESS.
  - Otherwise: idx++ -> PLAY_ON.
- Player input is ignored in GEN, PLAY_ON and PLAY_OFF, even if held.
- WAIT_PRESS: simon_turn=0 and tick counts.
  - player_pressed=1: latch cap <= player_num, tick <= 0 -> WAIT_RELEASE.
  - tick reaches TIMEOUT_TICKS-1 with no press: -> OVER.
  - A press on the timeout cycle is accepted (press wins).
- WAIT_RELEASE: the colour latched at press start is final; no timeout. player_pressed=0 -> CHECK.
- CHECK (1 cycle):
  - cap != seq[idx] -> OVER.
  - Match and idx<len-1: idx++ -> WAIT_PRESS (tick=0).
  - Match and idx==len-1 and len==MAX_LEN -> WIN.
  - Otherwise -> GEN, which adds one colour and replays the whole sequence.
- OVER / WIN: game_over or win is held high and round_len keeps its final value. start=1 -> len <= 0, then GEN.
- Entering GEN from IDLE, OVER or WIN takes 1 cycle. First simon_pressed rises 2 cycles after start is sampled.
- round_len is always equal to len. len never exceeds MAX_LEN.
- Unused state encodings -> IDLE.

Decomposition:
- Package simon_pkg: state enum (IDLE, GEN, PLAY_ON, PLAY_OFF, WAIT_PRESS, WAIT_RELEASE, CHECK, OVER, WIN) and colour_t (2 bits).
- Sub-module simon_lfsr8: step enable, SEED parameter, 8-bit state output.
- Sequence storage (MAX_LEN x 2 register file), counters and FSM live in the top module.

Test Plan:
- Reset, then check outputs -> all outputs 0. Assert reset mid-PLAY_ON -> next cycle state IDLE, simon_pressed=0, round_len=0.
- Use ON_TICKS=2, OFF_TICKS=1. Pulse start, then answer each round correctly (press 2 cycles, release) -> sequences are 2 / 2,1 / 2,1,2. simon_pressed pulses are exactly 2 cycles wide with 1-cycle gaps, and round_len steps 1, 2, 3.
- In round 2, press colour 3 at idx 1 -> game_over=1 the cycle after release and round_len stays 2. Then start -> round_len=1, and the colour played is the 4th LFSR output, not 2.
- With TIMEOUT_TICKS=5, give no press -> game_over after exactly 5 WAIT_PRESS cycles. Repeat with the press landing on the 5th cycle -> the press is accepted.
- Toggle player_pressed during playback, and change player_num while held (latched 1, then 0, answer 1) -> playback is unaffected and the check uses 1, so it passes.
- With MAX_LEN=3 and all answers correct -> win=1 after the third round's check, and no further GEN occurs.
